// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants used by the fetch front end.
package mips_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned MAX_ADDR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // pc is carried at full width; narrower address spaces use the low bits.
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [MAX_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface mips_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import mips_pkg::*;

  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_pc;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_W-1:0]   imem_req_addr;
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;

  logic                dec_valid;
  logic                dec_ready;
  logic [INSTR_W-1:0]  dec_instr;
  logic [ADDR_W-1:0]   dec_pc;
  logic [ADDR_W-1:0]   dec_pc_plus4;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  dec_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output dec_ready
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Synchronous FIFO with flush; read data comes straight from the head slot.
module mips_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr_q] <= wdata;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited issue, in-order response
// tagging, prefetch buffering and redirect squashing.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  mips_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  fifo_count, tag_count;
  logic              fifo_full, fifo_empty, tag_full, tag_empty;
  logic [CNT_W:0]    credit_used;
  logic              redirect, rsp, req_fire, drop_now, push, pop;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      push_entry, head_entry;
  logic [ENT_W-1:0]  head_bits;
  logic              unused_status;

  assign redirect    = bus.redirect_valid;
  assign rsp         = bus.imem_rsp_valid;
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_count};

  assign bus.imem_req_valid = !rst && !redirect && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses in a redirect cycle belong to the squashed path by definition.
  assign drop_now = rsp && (redirect || (drop_cnt_q != '0));
  assign push     = rsp && !drop_now && !tag_empty;

  assign bus.dec_valid = !fifo_empty && !redirect;
  assign pop           = bus.dec_valid && bus.dec_ready;

  always_comb begin
    push_entry                = '0;
    push_entry.instr          = bus.imem_rsp_data;
    push_entry.pc[ADDR_W-1:0] = tag_head;
  end

  assign head_entry       = fetch_entry_t'(head_bits);
  assign bus.dec_instr    = head_entry.instr;
  assign bus.dec_pc       = head_entry.pc[ADDR_W-1:0];
  assign bus.dec_pc_plus4 = bus.dec_pc + ADDR_W'(PC_STEP);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp);
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      drop_cnt_d = out_cnt_q - CNT_W'(rsp);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Tag queue mirrors outstanding requests one-for-one, so it is never flushed.
  mips_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (rsp),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  mips_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign unused_status = ^{tag_count, tag_full, fifo_full};

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit with a latency-programmable memory.
module tb_mips_fetch_unit;

  logic clk = 1'b0;
  logic rst, rst8;
  int   ecnt = 0;
  int   lat  = 1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  mips_fetch_unit_if #(.ADDR_W(32)) bus ();
  mips_fetch_unit_if #(.ADDR_W(8))  bus8 ();

  mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC), .FIFO_DEPTH(4)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  pend_t       pend8[$];
  logic [31:0] req_addr_q[$], req_edge_q[$];
  logic [31:0] dec_pc_q[$], dec_instr_q[$], dec_p4_q[$], dec_edge_q[$];
  logic [31:0] req8_q[$], dec8_pc_q[$], dec8_p4_q[$];

  // Memory model and transfer logger; ecnt is the index of the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      if (pend.size() > 0 && pend[0].due == ecnt) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pend[0].addr ^ 32'hC0DE_0000;
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back('{bus.imem_req_addr, ecnt + lat});
        req_addr_q.push_back(bus.imem_req_addr);
        req_edge_q.push_back(32'(ecnt));
      end
      if (bus.dec_valid && bus.dec_ready) begin
        dec_pc_q.push_back(bus.dec_pc);
        dec_instr_q.push_back(bus.dec_instr);
        dec_p4_q.push_back(bus.dec_pc_plus4);
        dec_edge_q.push_back(32'(ecnt));
      end
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      pend8.delete();
      bus8.imem_rsp_valid = 1'b0;
      bus8.imem_rsp_data  = '0;
    end else begin
      if (pend8.size() > 0 && pend8[0].due == ecnt) begin
        bus8.imem_rsp_valid = 1'b1;
        bus8.imem_rsp_data  = pend8[0].addr | 32'hC0DE_0000;
        void'(pend8.pop_front());
      end else begin
        bus8.imem_rsp_valid = 1'b0;
      end
      if (bus8.imem_req_valid && bus8.imem_req_ready) begin
        pend8.push_back('{{24'h0, bus8.imem_req_addr}, ecnt + 1});
        req8_q.push_back({24'h0, bus8.imem_req_addr});
      end
      if (bus8.dec_valid && bus8.dec_ready) begin
        dec8_pc_q.push_back({24'h0, bus8.dec_pc});
        dec8_p4_q.push_back({24'h0, bus8.dec_pc_plus4});
      end
    end
  end

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete(); req_edge_q.delete();
    dec_pc_q.delete(); dec_instr_q.delete(); dec_p4_q.delete(); dec_edge_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick(2);
  endtask

  task automatic test_reset();
    tick(2);
    #3;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %h want 0", bus.imem_req_valid); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %h want 0", bus.dec_valid); end
    checks++; if (bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h want 0", bus.imem_req_addr); end
    checks++; if (bus.dec_instr !== 32'h0) begin errors++; $display("FAIL rst_dec_instr got %h want 0", bus.dec_instr); end
    checks++; if (bus.dec_pc !== 32'h0) begin errors++; $display("FAIL rst_dec_pc got %h want 0", bus.dec_pc); end
    checks++; if (bus.dec_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_dec_pc_plus4 got %h want 4", bus.dec_pc_plus4); end
    checks++; if (bus8.imem_req_addr !== 8'hFC) begin errors++; $display("FAIL rst8_req_addr got %h want fc", bus8.imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    lat = 1; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %h want 1", bus.imem_req_valid); end
    tick(10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_at(req_addr_q, i) !== exp_addr[i]) begin
        errors++; $display("FAIL stream_req_addr[%0d] got %h want %h", i, q_at(req_addr_q, i), exp_addr[i]);
      end
    end
    checks++; if (q_at(dec_pc_q, 0) !== 32'h0) begin errors++; $display("FAIL stream_dec_pc0 got %h want 0", q_at(dec_pc_q, 0)); end
    checks++; if (q_at(dec_p4_q, 0) !== 32'h4) begin errors++; $display("FAIL stream_dec_p4_0 got %h want 4", q_at(dec_p4_q, 0)); end
    checks++; if (q_at(dec_instr_q, 0) !== 32'hC0DE_0000) begin errors++; $display("FAIL stream_dec_instr0 got %h want c0de0000", q_at(dec_instr_q, 0)); end
    checks++; if (q_at(dec_pc_q, 3) !== 32'hC) begin errors++; $display("FAIL stream_dec_pc3 got %h want c", q_at(dec_pc_q, 3)); end
    checks++;
    if ((q_at(dec_edge_q, 0) - q_at(req_edge_q, 0)) !== 32'd2) begin
      errors++; $display("FAIL stream_latency got %0d want 2", q_at(dec_edge_q, 0) - q_at(req_edge_q, 0));
    end
    checks++;
    if ((q_at(dec_edge_q, 3) - q_at(dec_edge_q, 0)) !== 32'd3) begin
      errors++; $display("FAIL stream_throughput got %0d want 3", q_at(dec_edge_q, 3) - q_at(dec_edge_q, 0));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    lat = 1; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b0;
    clear_logs();
    rst = 1'b0;
    tick(8);
    #3;
    checks++; if (req_addr_q.size() !== 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", req_addr_q.size()); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %h want 0", bus.imem_req_valid); end
    checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL bp_dec_valid got %h want 1", bus.dec_valid); end
    bus.dec_ready = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_at(dec_pc_q, i) !== exp_pc[i]) begin
        errors++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, q_at(dec_pc_q, i), exp_pc[i]);
      end
    end
    checks++; if (q_at(req_addr_q, 4) !== 32'h10) begin errors++; $display("FAIL bp_resume_addr got %h want 10", q_at(req_addr_q, 4)); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    tick(2);
    bus.imem_req_ready = 1'b0;
    bus.redirect_pc    = 32'h100;
    bus.redirect_valid = 1'b1;
    #3;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdi_req_valid got %h want 0", bus.imem_req_valid); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rdi_dec_valid got %h want 0", bus.dec_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #3;
    checks++; if (bus.imem_req_addr !== 32'h100) begin errors++; $display("FAIL rdi_req_addr got %h want 100", bus.imem_req_addr); end
    tick(12);
    checks++; if (q_at(req_addr_q, 2) !== 32'h100) begin errors++; $display("FAIL rdi_third_req got %h want 100", q_at(req_addr_q, 2)); end
    checks++;
    if ((q_at(req_edge_q, 2) - q_at(req_edge_q, 1)) !== 32'd2) begin
      errors++; $display("FAIL rdi_issue_gap got %0d want 2", q_at(req_edge_q, 2) - q_at(req_edge_q, 1));
    end
    checks++; if (q_at(dec_pc_q, 0) !== 32'h100) begin errors++; $display("FAIL rdi_first_dec_pc got %h want 100", q_at(dec_pc_q, 0)); end
    checks++; if (q_at(dec_instr_q, 0) !== 32'hC0DE_0100) begin errors++; $display("FAIL rdi_first_instr got %h want c0de0100", q_at(dec_instr_q, 0)); end
    checks++;
    if ((q_at(dec_edge_q, 0) - q_at(req_edge_q, 2)) !== 32'd4) begin
      errors++; $display("FAIL rdi_new_latency got %0d want 4", q_at(dec_edge_q, 0) - q_at(req_edge_q, 2));
    end
  endtask

  task automatic test_redirect_same_rsp();
    do_reset();
    lat = 1; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    tick(2);
    bus.redirect_pc    = 32'h203;
    bus.redirect_valid = 1'b1;
    #3;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rds_dec_valid got %h want 0", bus.dec_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rds_req_valid got %h want 0", bus.imem_req_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #3;
    checks++; if (bus.imem_req_addr !== 32'h200) begin errors++; $display("FAIL rds_req_addr got %h want 200", bus.imem_req_addr); end
    tick(8);
    checks++; if (q_at(req_addr_q, 2) !== 32'h200) begin errors++; $display("FAIL rds_third_req got %h want 200", q_at(req_addr_q, 2)); end
    checks++; if (q_at(dec_pc_q, 0) !== 32'h200) begin errors++; $display("FAIL rds_first_dec_pc got %h want 200", q_at(dec_pc_q, 0)); end
    checks++; if (q_at(dec_p4_q, 0) !== 32'h204) begin errors++; $display("FAIL rds_first_dec_p4 got %h want 204", q_at(dec_p4_q, 0)); end
  endtask

  task automatic test_wrap();
    rst8 = 1'b0;
    tick(6);
    checks++; if (q_at(req8_q, 0) !== 32'hFC) begin errors++; $display("FAIL wrap_req0 got %h want fc", q_at(req8_q, 0)); end
    checks++; if (q_at(req8_q, 1) !== 32'h00) begin errors++; $display("FAIL wrap_req1 got %h want 00", q_at(req8_q, 1)); end
    checks++; if (q_at(dec8_pc_q, 0) !== 32'hFC) begin errors++; $display("FAIL wrap_dec_pc0 got %h want fc", q_at(dec8_pc_q, 0)); end
    checks++; if (q_at(dec8_p4_q, 0) !== 32'h00) begin errors++; $display("FAIL wrap_dec_p4_0 got %h want 00", q_at(dec8_p4_q, 0)); end
    checks++; if (q_at(dec8_pc_q, 1) !== 32'h00) begin errors++; $display("FAIL wrap_dec_pc1 got %h want 00", q_at(dec8_pc_q, 1)); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 1; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b0;
    clear_logs();
    rst = 1'b0;
    tick(3);
    bus.imem_req_ready = 1'b0;
    tick();
    #1;
    checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_dec_valid got %h want 1", bus.dec_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_req_valid got %h want 1", bus.imem_req_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL mid_dec_valid got %h want 0", bus.dec_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got %h want 0", bus.imem_req_valid); end
    checks++; if (bus.dec_pc !== 32'h0) begin errors++; $display("FAIL mid_dec_pc got %h want 0", bus.dec_pc); end
    tick(2);
    bus.dec_ready = 1'b1; bus.imem_req_ready = 1'b1;
    clear_logs();
    rst = 1'b0;
    tick(6);
    checks++; if (q_at(req_addr_q, 0) !== 32'h0) begin errors++; $display("FAIL mid_restart_req0 got %h want 0", q_at(req_addr_q, 0)); end
    checks++; if (q_at(req_addr_q, 1) !== 32'h4) begin errors++; $display("FAIL mid_restart_req1 got %h want 4", q_at(req_addr_q, 1)); end
    checks++; if (q_at(dec_pc_q, 0) !== 32'h0) begin errors++; $display("FAIL mid_restart_dec_pc got %h want 0", q_at(dec_pc_q, 0)); end
  endtask

  initial begin
    rst  = 1'b1;
    rst8 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b1;
    bus.dec_ready       = 1'b1;
    bus8.redirect_valid = 1'b0;
    bus8.redirect_pc    = '0;
    bus8.imem_req_ready = 1'b1;
    bus8.dec_ready      = 1'b1;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_rsp();
    test_wrap();
    test_reset_midstream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
